mem_port_arbiter: RTL and testbench

Arbitrates a single-ported, fixed-latency memory between the instruction-fetch (IF) requester and the load/store (D) requester of the pipelined RISC-V core, replacing the per-port memory model with one shared array. Grants at most one request per cycle, tracks in-flight reads in an owner pipeline, and routes each read response back to the requester that issued it. Sits between the IF/MEM pipeline stages and the memory array; stage stalls come from the grant outputs.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_owner_pipe.sv | 34 +++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/D memory port arbiter: response owner tag and owner pipeline entry.
package mem_port_arbiter_pkg;

  localparam int MEM_LATENCY_MAX = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } mem_owner_e;

  typedef struct packed {
    logic       valid;
    mem_owner_e owner;
  } owner_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);

  // Handshake: a requester raises *_req with stable payload and holds it until the cycle
  // its *_gnt is 1; that cycle's clk edge issues the access. Responses need no ready.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_misaligned;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_misaligned,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_misaligned,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_port_arbiter_owner_pipe.sv
// Fixed-depth shift register of response owner tags; the tail marks which port owns mem_rdata.
module owner_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  owner_entry_t push_i,
  output owner_entry_t tail_o
);

  owner_entry_t [DEPTH-1:0] stage_q;
  owner_entry_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = push_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the IF and D requesters and routes read data back.
// Build option: define ARB_RR_EN for round-robin contention; default is D-over-IF priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus_io
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY out of range");
  end

  logic         grant_if;
  logic         grant_d;
  logic         d_wins;
  logic         mis_d;
  logic         mis_q;
  owner_entry_t push;
  owner_entry_t tail;
  logic         unused_addr_bits;

`ifdef ARB_RR_EN
  mem_owner_e last_owner_q;
  mem_owner_e last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_if) begin
      last_owner_d = OWN_IF;
    end else if (grant_d) begin
      last_owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  assign d_wins = (last_owner_q == OWN_IF);
`else
  assign d_wins = 1'b1;
`endif

  // Grants are held low during reset so nothing is issued while the owner pipe is cleared.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!rst) begin
      if (bus_io.d_req && (!bus_io.if_req || d_wins)) begin
        grant_d = 1'b1;
      end else if (bus_io.if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    bus_io.mem_we    = 1'b0;
    bus_io.mem_addr  = '0;
    bus_io.mem_wdata = '0;
    bus_io.mem_be    = 4'h0;
    if (grant_d) begin
      bus_io.mem_we    = bus_io.d_we;
      bus_io.mem_addr  = bus_io.d_addr[ADDR_W-1:2];
      bus_io.mem_wdata = bus_io.d_wdata;
      bus_io.mem_be    = bus_io.d_be;
    end else if (grant_if) begin
      bus_io.mem_addr  = bus_io.if_addr[ADDR_W-1:2];
      bus_io.mem_be    = 4'hF;
    end
  end

  assign bus_io.if_gnt  = grant_if;
  assign bus_io.d_gnt   = grant_d;
  assign bus_io.mem_req = grant_if | grant_d;

  // Stores still shift an invalid slot so every read keeps its exact latency.
  assign push.valid = grant_if | (grant_d & ~bus_io.d_we);
  assign push.owner = grant_d ? OWN_D : OWN_IF;

  owner_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_owner_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .tail_o (tail)
  );

  assign bus_io.if_rvalid = tail.valid && (tail.owner == OWN_IF);
  assign bus_io.d_rvalid  = tail.valid && (tail.owner == OWN_D);
  assign bus_io.if_rdata  = bus_io.if_rvalid ? bus_io.mem_rdata : 32'h0;
  assign bus_io.d_rdata   = bus_io.d_rvalid  ? bus_io.mem_rdata : 32'h0;

  assign mis_d = grant_d && (bus_io.d_addr[1:0] != 2'b00) &&
                 ((bus_io.d_be == 4'hF) || !bus_io.d_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign bus_io.d_misaligned = mis_q;
  assign unused_addr_bits    = ^bus_io.if_addr[1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a response-queue reference model.
module tb_mem_port_arbiter;

  localparam int LAT    = 3;
  localparam int ADDR_W = 32;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .MEM_LATENCY (LAT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE, 8'h00, 8'(i)};
  endfunction

  // Memory array environment: fixed-latency read data line, byte-enabled writes.
  logic [31:0] mem_q [256];
  bit          written [256];
  logic [31:0] rd_pipe [LAT];
  logic [31:0] cur_word;
  logic [7:0]  wa;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    wa = bus.mem_addr[7:0];
    if (bus.mem_req && !bus.mem_we)
      rd_pipe[0] <= written[wa] ? mem_q[wa] : init_word(int'(wa));
    else
      rd_pipe[0] <= 32'hDEAD_BEEF;
    if (bus.mem_req && bus.mem_we) begin
      cur_word = written[wa] ? mem_q[wa] : init_word(int'(wa));
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) cur_word[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      mem_q[wa]   <= cur_word;
      written[wa] <= 1'b1;
    end
  end

  assign bus.mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [64:0] exp_q [$];   // {due_cycle[31:0], owner(1=D), data[31:0]}
  logic        m_last_d;
  logic        m_mis;
  int          cyc;
  int          total;
  int          bad;

  logic        p_if;
  logic [31:0] p_if_addr;
  logic        p_d;
  logic        p_d_we;
  logic [31:0] p_d_addr;
  logic [31:0] p_d_wdata;
  logic [3:0]  p_d_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic        e_if;
    logic        e_d;
    logic        e_rv_if;
    logic        e_rv_d;
    logic [31:0] e_data;
    logic [64:0] h;
    logic [7:0]  w;
    bus.if_req  = p_if;
    bus.if_addr = p_if_addr;
    bus.d_req   = p_d;
    bus.d_we    = p_d_we;
    bus.d_addr  = p_d_addr;
    bus.d_wdata = p_d_wdata;
    bus.d_be    = p_d_be;
    #1;
    if (rst) begin
      exp_q.delete();
      m_last_d = 1'b0;
      m_mis    = 1'b0;
    end
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!rst) begin
      if (p_if && p_d) begin
`ifdef ARB_RR_EN
        if (m_last_d) e_if = 1'b1; else e_d = 1'b1;
`else
        e_d = 1'b1;
`endif
      end else if (p_if) e_if = 1'b1;
      else if (p_d) e_d = 1'b1;
    end
    chk("if_gnt", 64'(bus.if_gnt), 64'(e_if));
    chk("d_gnt", 64'(bus.d_gnt), 64'(e_d));
    chk("mem_req", 64'(bus.mem_req), 64'(e_if | e_d));
    if (e_d) begin
      chk("mem_we_d", 64'(bus.mem_we), 64'(p_d_we));
      chk("mem_addr_d", 64'(bus.mem_addr), 64'(p_d_addr >> 2));
      chk("mem_wdata_d", 64'(bus.mem_wdata), 64'(p_d_wdata));
      chk("mem_be_d", 64'(bus.mem_be), 64'(p_d_be));
    end else if (e_if) begin
      chk("mem_we_if", 64'(bus.mem_we), 64'(0));
      chk("mem_addr_if", 64'(bus.mem_addr), 64'(p_if_addr >> 2));
      chk("mem_be_if", 64'(bus.mem_be), 64'(4'hF));
    end else begin
      chk("mem_we_idle", 64'(bus.mem_we), 64'(0));
      chk("mem_addr_idle", 64'(bus.mem_addr), 64'(0));
      chk("mem_wdata_idle", 64'(bus.mem_wdata), 64'(0));
      chk("mem_be_idle", 64'(bus.mem_be), 64'(0));
    end
    chk("d_misaligned", 64'(bus.d_misaligned), 64'(m_mis));
    e_rv_if = 1'b0;
    e_rv_d  = 1'b0;
    e_data  = 32'h0;
    if (exp_q.size() != 0 && exp_q[0][64:33] == 32'(cyc)) begin
      h = exp_q.pop_front();
      if (h[32]) e_rv_d = 1'b1; else e_rv_if = 1'b1;
      e_data = h[31:0];
    end
    chk("if_rvalid", 64'(bus.if_rvalid), 64'(e_rv_if));
    chk("d_rvalid", 64'(bus.d_rvalid), 64'(e_rv_d));
    chk("if_rdata", 64'(bus.if_rdata), 64'(e_rv_if ? e_data : 32'h0));
    chk("d_rdata", 64'(bus.d_rdata), 64'(e_rv_d ? e_data : 32'h0));
    @(posedge clk);
    if (!rst) begin
      m_mis = e_d && (p_d_addr[1:0] != 2'b00) && ((p_d_be == 4'hF) || !p_d_we);
      if (e_if) begin
        exp_q.push_back({32'(cyc + LAT), 1'b0, ref_mem[p_if_addr[9:2]]});
        m_last_d = 1'b0;
        p_if     = 1'b0;
      end
      if (e_d) begin
        w = p_d_addr[9:2];
        if (p_d_we) begin
          for (int b = 0; b < 4; b++)
            if (p_d_be[b]) ref_mem[w][8*b +: 8] = p_d_wdata[8*b +: 8];
        end else begin
          exp_q.push_back({32'(cyc + LAT), 1'b1, ref_mem[w]});
        end
        m_last_d = 1'b1;
        p_d      = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_if(input logic [31:0] a);
    p_if      = 1'b1;
    p_if_addr = a;
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    p_d       = 1'b1;
    p_d_we    = we;
    p_d_addr  = a;
    p_d_wdata = wd;
    p_d_be    = be;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    m_last_d = 1'b0;
    m_mis    = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    p_if = 1'b0; p_if_addr = 32'h0;
    p_d = 1'b0; p_d_we = 1'b0; p_d_addr = 32'h0; p_d_wdata = 32'h0; p_d_be = 4'h0;

    // Reset, including requests held during reset: nothing may be granted.
    rst = 1'b1;
    drain(1);
    set_if(32'h40);
    set_d(1'b0, 32'h44, 32'h0, 4'hF);
    drain(1);
    p_if = 1'b0;
    p_d  = 1'b0;
    rst  = 1'b0;
    drain(1);

    // IF-only stream at 0x0, 0x4, 0x8.
    set_if(32'h0); cycle();
    set_if(32'h4); cycle();
    set_if(32'h8); cycle();
    drain(LAT + 1);

    // Contention: D load 0x88 vs IF 0x10, then continuous dual requests.
    set_if(32'h10);
    set_d(1'b0, 32'h88, 32'h0, 4'hF);
    cycle();
    cycle();
    drain(LAT + 1);
    for (int k = 0; k < 4; k++) begin
      if (!p_if) set_if(32'h20 + 32'(4 * k));
      if (!p_d) set_d(1'b0, 32'h60 + 32'(4 * k), 32'h0, 4'hF);
      cycle();
    end
    p_if = 1'b0;
    p_d  = 1'b0;
    drain(LAT + 1);

    // Store 123 to 0x78 then load it back.
    set_d(1'b1, 32'h78, 32'd123, 4'hF); cycle();
    set_d(1'b0, 32'h78, 32'h0, 4'hF);   cycle();
    drain(LAT + 1);

    // Interleaved IF / D / IF reads.
    set_if(32'h0);                      cycle();
    set_d(1'b0, 32'hA0, 32'h0, 4'hF);   cycle();
    set_if(32'h4);                      cycle();
    drain(LAT + 1);

    // Misaligned load at 0x8A.
    set_d(1'b0, 32'h8A, 32'h0, 4'hF);   cycle();
    drain(LAT + 1);

    // Reset while two reads are in flight: their responses must never appear.
    set_if(32'h20);                     cycle();
    set_d(1'b0, 32'h24, 32'h0, 4'hF);   cycle();
    rst = 1'b1;
    set_if(32'h28);
    drain(2);
    p_if = 1'b0;
    rst  = 1'b0;
    drain(LAT + 2);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if (!p_if && $urandom_range(0, 99) < 60)
        set_if({22'h0, 8'($urandom_range(0, 63)), 2'b00});
      if (!p_d && $urandom_range(0, 99) < 50)
        set_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
              4'($urandom_range(0, 15)));
      cycle();
    end
    p_if = 1'b0;
    p_d  = 1'b0;
    drain(LAT + 2);
    chk("resp_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
